// File: rtl/sonar_echo_ranger.sv
// Ultrasonic ranging controller: one trigger pulse per start rising edge,
// echo width timed in centimetre steps, result or timeout strobed once.
//
//  state       | meaning
//  ------------+-------------------------------------------------------
//  S_IDLE      | waiting for a start rising edge, busy low
//  S_TRIG      | driving the transducer trigger for TRIG_CYCLES cycles
//  S_WAIT_RISE | trigger done, waiting for the synchronised echo to rise
//  S_MEASURE   | echo high, accumulating cycles into cm units
module sonar_echo_ranger #(
    parameter int TRIG_CYCLES    = 500,
    parameter int CM_CYCLES      = 2900,
    parameter int TIMEOUT_CYCLES = 1500000,
    parameter int DIST_W         = 9
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic              echo,
    output logic              trig,
    output logic [DIST_W-1:0] distance,
    output logic              dist_valid,
    output logic              timeout,
    output logic              busy
);

    localparam int TRIG_W = $clog2(TRIG_CYCLES + 1);
    localparam int SUB_W  = $clog2(CM_CYCLES + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [TRIG_W-1:0] TRIG_LOAD = TRIG_W'(TRIG_CYCLES - 1);
    localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(CM_CYCLES - 1);
    localparam logic [TO_W-1:0]   TO_LOAD   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DIST_W-1:0] CM_MAX    = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT_RISE,
        S_MEASURE
    } state_t;

    state_t state, state_nx;

    logic              armed;
    logic              start_q;
    logic              echo_m, echo_s, echo_s_q;
    logic [TRIG_W-1:0] trig_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [SUB_W-1:0]  sub_cnt;
    logic [DIST_W-1:0] cm_cnt;

    logic start_edge, echo_rise, echo_fall;
    logic load_trig, start_meas, capture, count_en;

    // A start level already high when reset releases is not a rising edge,
    // so edge detection is held off for the first clock after reset.
    assign start_edge = start & ~start_q & armed;
    assign echo_rise  = echo_s & ~echo_s_q;
    assign echo_fall  = ~echo_s & echo_s_q;

    // Input registers: start edge detector and two-flop echo synchroniser.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            armed    <= 1'b0;
            start_q  <= 1'b0;
            echo_m   <= 1'b0;
            echo_s   <= 1'b0;
            echo_s_q <= 1'b0;
        end else begin
            armed    <= 1'b1;
            start_q  <= start;
            echo_m   <= echo;
            echo_s   <= echo_m;
            echo_s_q <= echo_s;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= S_IDLE;
        else      state <= state_nx;
    end

    // Next-state and Moore/Mealy outputs. Timeout beats a late rise,
    // but a fall in the terminal cycle beats the timeout.
    always_comb begin
        state_nx   = state;
        trig       = 1'b0;
        busy       = 1'b1;
        timeout    = 1'b0;
        load_trig  = 1'b0;
        start_meas = 1'b0;
        capture    = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start_edge) begin
                    state_nx  = S_TRIG;
                    load_trig = 1'b1;
                end
            end
            S_TRIG: begin
                trig = 1'b1;
                if (trig_cnt == '0) begin
                    state_nx   = S_WAIT_RISE;
                    start_meas = 1'b1;
                end
            end
            S_WAIT_RISE: begin
                if (to_cnt == '0) begin
                    timeout  = 1'b1;
                    state_nx = S_IDLE;
                end else if (echo_rise) begin
                    state_nx = S_MEASURE;
                end
            end
            S_MEASURE: begin
                if (echo_fall) begin
                    capture  = 1'b1;
                    state_nx = S_IDLE;
                end else if (to_cnt == '0) begin
                    timeout  = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // The rise cycle itself is an echo-high cycle, so counting follows the
    // next state rather than the current one.
    assign count_en = echo_s && (state_nx == S_MEASURE);

    // Trigger width and echo timeout down-counters.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            trig_cnt <= '0;
            to_cnt   <= '0;
        end else begin
            if (load_trig)
                trig_cnt <= TRIG_LOAD;
            else if (state == S_TRIG && trig_cnt != '0)
                trig_cnt <= trig_cnt - 1'b1;

            if (start_meas)
                to_cnt <= TO_LOAD;
            else if ((state == S_WAIT_RISE || state == S_MEASURE) && to_cnt != '0)
                to_cnt <= to_cnt - 1'b1;
        end
    end

    // Echo width in cm: sub-counter wraps every CM_CYCLES, cm saturates.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sub_cnt <= '0;
            cm_cnt  <= '0;
        end else if (start_meas) begin
            sub_cnt <= '0;
            cm_cnt  <= '0;
        end else if (count_en) begin
            if (sub_cnt == SUB_LAST) begin
                sub_cnt <= '0;
                if (cm_cnt != CM_MAX) cm_cnt <= cm_cnt + 1'b1;
            end else begin
                sub_cnt <= sub_cnt + 1'b1;
            end
        end
    end

    // Result register and its one-cycle strobe.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            distance   <= '0;
            dist_valid <= 1'b0;
        end else begin
            dist_valid <= capture;
            if (capture) distance <= cm_cnt;
        end
    end

endmodule

// File: tb/tb_sonar_echo_ranger.sv
// Bench for sonar_echo_ranger: directed scenarios plus randomised echo
// placement/width, checked against an arithmetic timing model.
module tb_sonar_echo_ranger;

    localparam int TRIG_CYCLES    = 5;
    localparam int CM_CYCLES      = 10;
    localparam int TIMEOUT_CYCLES = 200;
    localparam int DIST_W         = 4;
    localparam int DIST_MAX       = (1 << DIST_W) - 1;

    logic              clk = 1'b0;
    logic              clr = 1'b0;
    logic              start = 1'b0;
    logic              echo = 1'b0;
    logic              trig;
    logic [DIST_W-1:0] distance;
    logic              dist_valid;
    logic              timeout;
    logic              busy;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_dist = 0;

    sonar_echo_ranger #(
        .TRIG_CYCLES(TRIG_CYCLES),
        .CM_CYCLES(CM_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .DIST_W(DIST_W)
    ) dut (
        .clk(clk),
        .clr(clr),
        .start(start),
        .echo(echo),
        .trig(trig),
        .distance(distance),
        .dist_valid(dist_valid),
        .timeout(timeout),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Counts trigger-high samples; returns on the first low sample after them
    // (sample t=1 of the measurement window).
    task automatic wait_trig(output int hi);
        hi = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (trig) hi++;
            else if (hi > 0) return;
        end
    endtask

    // Counts any activity on the outputs over a number of cycles.
    task automatic quiet_window(input int cycles, output int act);
        act = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (trig || busy || dist_valid || timeout) act++;
        end
    endtask

    // One measurement. Echo is driven high from window sample s for n samples.
    // Model: synchronised echo rises 2 samples later and falls at s+n+2; the
    // result is good when that fall lands no later than sample TIMEOUT_CYCLES,
    // giving dist_valid at s+n+3. Otherwise timeout shows at sample
    // TIMEOUT_CYCLES and busy drops one sample later.
    task automatic run_meas(input int s, input int n, input bit retrig);
        int hi;
        int dv_cnt = 0, dv_t = 0, dv_d = 0;
        int to_cnt = 0, to_t = 0, bz_t = 0;
        int both = 0, extra = 0, act;
        bit ok;
        ok = (n > 0) && (s + n + 2 <= TIMEOUT_CYCLES);
        chk("idle_before", int'(busy), 0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        wait_trig(hi);
        chk("trig_width", hi, TRIG_CYCLES);
        for (int t = 1; t <= TIMEOUT_CYCLES + 15; t++) begin
            if (t > 1) @(negedge clk);
            if (dist_valid) begin
                dv_cnt++;
                if (dv_t == 0) begin
                    dv_t = t;
                    dv_d = int'(distance);
                end
            end
            if (timeout) begin
                to_cnt++;
                if (to_t == 0) to_t = t;
            end
            if (dist_valid && timeout) both++;
            if (!busy && bz_t == 0) bz_t = t;
            if (trig) extra++;
            echo = (t >= s) && (t < s + n);
            if (retrig) begin
                if (t == s + 4) start = 1'b0;
                else if (t == s + 6) start = 1'b1;
            end else if (t == 3) begin
                start = 1'b0;
            end
        end
        echo = 1'b0;
        if (retrig) begin
            quiet_window(1000, act);
            chk("held_start_activity", act, 0);
            start = 1'b0;
        end
        repeat (5) @(negedge clk);
        chk("strobes_together", both, 0);
        chk("extra_trig", extra, 0);
        if (ok) begin
            exp_dist = (n / CM_CYCLES > DIST_MAX) ? DIST_MAX : n / CM_CYCLES;
            chk("dv_count", dv_cnt, 1);
            chk("dv_time", dv_t, s + n + 3);
            chk("distance", dv_d, exp_dist);
            chk("no_timeout", to_cnt, 0);
            chk("busy_drop_dv", bz_t, s + n + 3);
        end else begin
            chk("to_count", to_cnt, 1);
            chk("to_time", to_t, TIMEOUT_CYCLES);
            chk("no_dv", dv_cnt, 0);
            chk("busy_drop_to", bz_t, TIMEOUT_CYCLES + 1);
            chk("dist_kept", int'(distance), exp_dist);
        end
    endtask

    initial begin
        int hi, act, s, n;

        // Reset held with start and echo high.
        clr = 1'b0;
        start = 1'b1;
        echo = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_trig", int'(trig), 0);
        chk("rst_distance", int'(distance), 0);
        chk("rst_dv", int'(dist_valid), 0);
        chk("rst_timeout", int'(timeout), 0);
        chk("rst_busy", int'(busy), 0);
        clr = 1'b1;
        quiet_window(20, act);
        chk("idle_after_release", act, 0);
        start = 1'b0;
        echo = 1'b0;
        repeat (5) @(negedge clk);

        run_meas(20, 57, 1'b0);
        run_meas(20, 0, 1'b0);
        run_meas(10, 170, 1'b0);
        run_meas(20, 178, 1'b0);
        run_meas(20, 179, 1'b0);
        run_meas(15, 45, 1'b1);

        // Reset in the middle of the trigger pulse.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("trig_before_rst", int'(trig), 1);
        clr = 1'b0;
        #1;
        chk("rst_trig_mid_trig", int'(trig), 0);
        chk("rst_busy_mid_trig", int'(busy), 0);
        chk("rst_dist_mid_trig", int'(distance), 0);
        exp_dist = 0;
        @(negedge clk);
        clr = 1'b1;
        quiet_window(30, act);
        chk("quiet_after_trig_rst", act, 0);
        start = 1'b0;

        run_meas(10, 57, 1'b0);

        // Reset in the middle of an echo measurement.
        @(negedge clk);
        start = 1'b1;
        wait_trig(hi);
        chk("trig_width_pre_rst", hi, TRIG_CYCLES);
        echo = 1'b1;
        repeat (12) @(negedge clk);
        chk("busy_in_measure", int'(busy), 1);
        clr = 1'b0;
        #1;
        chk("rst_trig_mid_meas", int'(trig), 0);
        chk("rst_busy_mid_meas", int'(busy), 0);
        chk("rst_dist_mid_meas", int'(distance), 0);
        exp_dist = 0;
        echo = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        quiet_window(30, act);
        chk("quiet_after_meas_rst", act, 0);
        start = 1'b0;
        repeat (3) @(negedge clk);

        // Random echo positions and widths, covering both outcomes.
        for (int k = 0; k < 12; k++) begin
            s = int'($urandom_range(1, 60));
            n = int'($urandom_range(1, 200));
            if (n % CM_CYCLES == 0) n++;
            run_meas(s, n, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
